// File: rtl/handshake_slave_rx.sv
// handshake_slave_rx: receive side of a four-phase req/ack byte link.
// Captures one byte per handshake into a DEPTH-entry frame buffer and keeps
// a running 8-bit checksum, a completion flag and a sticky overflow flag.
module handshake_slave_rx #(
  parameter  int unsigned DEPTH    = 4,
  parameter  int unsigned ACK_HOLD = 1,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_in,
  input  logic [7:0]    data_in,
  output logic          ack_out,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    last_byte,
  output logic [CW-1:0] byte_count,
  output logic [7:0]    checksum,
  output logic          frame_done,
  output logic          overflow
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } state_t;

  localparam logic [3:0]    HOLD_LAST = 4'(ACK_HOLD - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_hold;
  logic          w_capture;
  logic          w_full;
  logic [7:0]    r_buf [DEPTH];
  logic [7:0]    r_last;
  logic [CW-1:0] r_count;
  logic [7:0]    r_sum;
  logic          r_done;
  logic          r_ovf;

  assign w_full = (r_count == FULL_CNT);

  // Next-state decode; the capture strobe fires on the IDLE->ACK_HI edge only.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_in) begin
          w_next_state = ACK_HI;
          w_capture    = 1'b1;
        end
      end
      ACK_HI: begin
        if ((r_hold >= HOLD_LAST) && !req_in) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register and ack hold counter (held at zero outside ACK_HI, so it is clear on entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state != ACK_HI) begin
        r_hold <= '0;
      end else if (r_hold != 4'hF) begin
        r_hold <= r_hold + 4'd1;
      end
    end
  end

  // Frame datapath: capture while not full, otherwise just flag overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_last  <= '0;
      r_count <= '0;
      r_sum   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_capture) begin
      if (!w_full) begin
        r_buf[r_count[AW-1:0]] <= data_in;
        r_last  <= data_in;
        r_sum   <= r_sum + data_in;
        r_count <= r_count + CW'(1);
        if (r_count == LAST_CNT) begin
          r_done <= 1'b1;
        end
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign ack_out    = (r_state == ACK_HI);
  assign rd_data    = r_buf[rd_addr];
  assign last_byte  = r_last;
  assign byte_count = r_count;
  assign checksum   = r_sum;
  assign frame_done = r_done;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_handshake_slave_rx.sv
// Directed bench for handshake_slave_rx: one instance with ACK_HOLD=1 driven
// by a modelled four-phase master, one with ACK_HOLD=4 for the hold timing.
module tb_handshake_slave_rx;

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] data;
  logic       ack;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] last_byte;
  logic [2:0] byte_count;
  logic [7:0] checksum;
  logic       frame_done;
  logic       overflow;

  logic       req4;
  logic [7:0] data4;
  logic       ack4;
  logic [1:0] rd_addr4;
  logic [7:0] rd_data4;
  logic [7:0] last_byte4;
  logic [2:0] byte_count4;
  logic [7:0] checksum4;
  logic       frame_done4;
  logic       overflow4;

  int n_checks = 0;
  int n_fail   = 0;

  handshake_slave_rx #(.DEPTH(4), .ACK_HOLD(1)) dut (
    .clk(clk), .rst(rst), .req_in(req), .data_in(data), .ack_out(ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .last_byte(last_byte),
    .byte_count(byte_count), .checksum(checksum),
    .frame_done(frame_done), .overflow(overflow)
  );

  handshake_slave_rx #(.DEPTH(4), .ACK_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req_in(req4), .data_in(data4), .ack_out(ack4),
    .rd_addr(rd_addr4), .rd_data(rd_data4), .last_byte(last_byte4),
    .byte_count(byte_count4), .checksum(checksum4),
    .frame_done(frame_done4), .overflow(overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_buf(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    rd_addr = idx;
    #1;
    check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  // Bounded wait for ack to reach a level, sampled on negedges.
  task automatic wait_ack(input logic lvl, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack === lvl) seen = 1'b1;
    end
    check(tag, {31'd0, ack}, {31'd0, lvl});
  endtask

  task automatic xfer(input logic [7:0] d);
    req  = 1'b1;
    data = d;
    wait_ack(1'b1, "xfer_ack_rise");
    req = 1'b0;
    wait_ack(1'b0, "xfer_ack_fall");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    rst = 1'b1; req = 1'b0; data = '0; rd_addr = '0;
    req4 = 1'b0; data4 = '0; rd_addr4 = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_ack",   {31'd0, ack},        32'd0);
    check("rst_count", {29'd0, byte_count}, 32'd0);
    check("rst_sum",   {24'd0, checksum},   32'd0);
    check("rst_last",  {24'd0, last_byte},  32'd0);
    check("rst_done",  {31'd0, frame_done}, 32'd0);
    check("rst_ovf",   {31'd0, overflow},   32'd0);
    for (int i = 0; i < 4; i++) check_buf(2'(i), 8'h00, "rst_buf");

    // First byte: exact one-cycle ack latency, outputs visible with ack
    req = 1'b1; data = 8'hA0;
    @(negedge clk);
    check("lat_ack",   {31'd0, ack},        32'd1);
    check("lat_last",  {24'd0, last_byte},  32'hA0);
    check("lat_count", {29'd0, byte_count}, 32'd1);
    check("lat_sum",   {24'd0, checksum},   32'hA0);
    req = 1'b0;
    @(negedge clk);
    check("rel_ack",   {31'd0, ack},        32'd0);

    // Rest of the frame
    xfer(8'hA1);
    xfer(8'hA2);
    check("pre_done",  {31'd0, frame_done}, 32'd0);
    xfer(8'hA3);
    check_buf(2'd0, 8'hA0, "frame_buf0");
    check_buf(2'd1, 8'hA1, "frame_buf1");
    check_buf(2'd2, 8'hA2, "frame_buf2");
    check_buf(2'd3, 8'hA3, "frame_buf3");
    check("frame_last",  {24'd0, last_byte},  32'hA3);
    check("frame_sum",   {24'd0, checksum},   32'h86);
    check("frame_count", {29'd0, byte_count}, 32'd4);
    check("frame_done",  {31'd0, frame_done}, 32'd1);
    check("frame_ovf",   {31'd0, overflow},   32'd0);

    // Fifth handshake on a full frame
    xfer(8'hFF);
    check("ovf_flag",  {31'd0, overflow},   32'd1);
    check("ovf_sum",   {24'd0, checksum},   32'h86);
    check("ovf_last",  {24'd0, last_byte},  32'hA3);
    check("ovf_count", {29'd0, byte_count}, 32'd4);
    check("ovf_done",  {31'd0, frame_done}, 32'd1);
    check_buf(2'd0, 8'hA0, "ovf_buf0");

    // Long request: capture edge plus 10 more high cycles gives 11 ack cycles
    do_reset();
    check("rst2_ovf", {31'd0, overflow}, 32'd0);
    req = 1'b1; data = 8'h55;
    hi_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (ack) hi_cnt++;
      data = 8'h66;
    end
    req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) hi_cnt++;
      else break;
    end
    check("long_ack_cycles", hi_cnt, 32'd11);
    check("long_ack_low",    {31'd0, ack},        32'd0);
    check("long_count",      {29'd0, byte_count}, 32'd1);
    check("long_sum",        {24'd0, checksum},   32'h55);
    check("long_last",       {24'd0, last_byte},  32'h55);

    // Checksum wrap
    do_reset();
    xfer(8'hF0);
    xfer(8'h20);
    check("wrap_sum",   {24'd0, checksum},   32'h10);
    check("wrap_count", {29'd0, byte_count}, 32'd2);

    // Reset during ACK_HI, request kept high through reset
    req = 1'b1; data = 8'h33;
    wait_ack(1'b1, "mid_ack_rise");
    check("mid_count_pre", {29'd0, byte_count}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_ack",   {31'd0, ack},        32'd0);
    check("mid_count", {29'd0, byte_count}, 32'd0);
    check("mid_sum",   {24'd0, checksum},   32'd0);
    check("mid_done",  {31'd0, frame_done}, 32'd0);
    for (int i = 0; i < 4; i++) check_buf(2'(i), 8'h00, "mid_buf");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ack",   {31'd0, ack},        32'd1);
    check("post_rst_count", {29'd0, byte_count}, 32'd1);
    check("post_rst_last",  {24'd0, last_byte},  32'h33);
    req = 1'b0;
    wait_ack(1'b0, "post_rst_fall");

    // ACK_HOLD=4 with a one-cycle request pulse
    req4 = 1'b1; data4 = 8'h5A;
    @(negedge clk);
    req4 = 1'b0;
    hi_cnt = ack4 ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack4) hi_cnt++;
      else break;
    end
    check("hold4_cycles", hi_cnt, 32'd4);
    check("hold4_low",    {31'd0, ack4},        32'd0);
    check("hold4_count",  {29'd0, byte_count4}, 32'd1);
    check("hold4_sum",    {24'd0, checksum4},   32'h5A);
    rd_addr4 = 2'd0;
    #1;
    check("hold4_buf0",   {24'd0, rd_data4},    32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_slave_rx.md
# handshake_slave_rx

Receive-side partner of the four-phase req/ack byte transmitter: samples `data_in` on each request, raises and holds `ack_out`, and releases it only after the master drops `req_in`. Accepted bytes go into a small frame buffer with a running 8-bit checksum. A completion flag is raised once `DEPTH` bytes have arrived. Sits directly downstream of the transmitter in the same clock domain, with no synchronisers.

## Interface
- `DEPTH`, default 4: bytes per frame (buffer entries), ≥2, power of two.
- `ACK_HOLD`, default 1: minimum cycles `ack_out` stays high per transfer, ≥1, ≤15.
- Derived: `AW = $clog2(DEPTH)`, `CW = $clog2(DEPTH+1)`.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `req_in`  in  1  request from master; `data_in` is valid whenever high.
- `data_in`  in  8  byte from master.
- `ack_out`  out  1  acknowledge to master (registered, state-decoded).
- `rd_addr`  in  AW  buffer read index.
- `rd_data`  out  8  combinational `buffer[rd_addr]`.
- `last_byte`  out  8  most recently accepted byte.
- `byte_count`  out  CW  bytes accepted this frame; saturates at `DEPTH`.
- `checksum`  out  8  sum of accepted bytes, mod 256.
- `frame_done`  out  1  sticky; high when `byte_count == DEPTH`.
- `overflow`  out  1  sticky; a request arrived while the frame was full.

## Operation
- States: IDLE, ACK_HI.
  - IDLE: `ack_out=0`. If `req_in=1`, go to ACK_HI and perform the capture step below on that same edge.
  - ACK_HI: `ack_out=1`. `hold_cnt` increments each cycle in ACK_HI (saturating) and is cleared on entry.
  - ACK_HI exit: go to IDLE when `hold_cnt >= ACK_HOLD-1` and `req_in==0`. Otherwise stay.
  - ACK_HI never exits while `req_in=1`, whatever the hold count.
- Capture step, when not full (`byte_count < DEPTH`):
  - `buffer[byte_count[AW-1:0]] <= data_in`
  - `last_byte <= data_in`
  - `checksum <= checksum + data_in` (8-bit wrap)
  - `byte_count <= byte_count + 1`
  - If the new count equals `DEPTH`, set `frame_done` on the same edge.
- Capture step, when full: the handshake completes normally, so the master never deadlocks. Buffer, `last_byte`, `checksum` and `byte_count` are unchanged, and `overflow` is set.
- Only one capture per handshake. A request held high across many cycles produces one byte.
- `frame_done` and `overflow` clear only on `rst`. No other frame-restart mechanism exists.
- Reset values: state IDLE, `ack_out=0`, `byte_count=0`, `checksum=0x00`, `last_byte=0x00`, all buffer entries 0x00, `frame_done=0`, `overflow=0`, `hold_cnt=0`.
- Illegal state encodings return to IDLE.

## Timing
- Request to ack: `req_in` sampled high at edge N gives `ack_out=1` after edge N. That is one cycle of latency, with data captured at edge N.
- Release:
  - `req_in` sampled low at edge M with the hold satisfied gives `ack_out=0` after edge M.
  - With `ACK_HOLD=1`, `ack_out` is high for exactly the number of cycles `req_in` stays high after capture, plus one.
  - A larger `ACK_HOLD` extends the high time to at least `ACK_HOLD` cycles.
- Capture outputs (`last_byte`, `checksum`, `byte_count`, `frame_done`) update on the capture edge and are visible in the cycle `ack_out` first reads 1.
- `rd_data` has zero-cycle latency from `rd_addr`. A read of the entry being written returns the old value until the edge.
- Reset mid-handshake: `rst` high at any edge forces IDLE and `ack_out=0` after that edge, regardless of `req_in`. If `req_in` is still high after reset releases, IDLE captures it as a new byte.
- Paired with the transmitter (two cycles between the transmitter's reset release and the next request edge), a full 4-byte frame completes without stalls. Neither side waits on a combinational path through the other.

## Test plan
- Paired with the transmitter (data 0xA0–0xA3), `DEPTH=4`, `ACK_HOLD=1`:
  - Buffer reads back A0, A1, A2, A3; `last_byte=0xA3`; `checksum=0x86`; `byte_count=4`; `frame_done=1`; `overflow=0`.
  - The transmitter's done output goes high.
- `req_in` held high for 10 cycles with `data_in=0x55`, then dropped: exactly one capture (`byte_count=1`, `checksum=0x55`), `ack_out` high for 11 cycles, then low.
- `ACK_HOLD=4`, one-cycle `req_in` pulse: `ack_out` high exactly 4 cycles; one byte captured.
- Fifth handshake after frame full, `data_in=0xFF`: `ack_out` handshakes normally; `overflow=1`; `checksum`, `last_byte` and `byte_count` unchanged.
- Checksum wrap with bytes 0xF0, 0x20: `checksum=0x10`.
- `rst` asserted while in ACK_HI after 2 bytes: next cycle `ack_out=0`, `byte_count=0`, `checksum=0`, `frame_done=0`, buffer entries read 0x00.
